adc_capture_fifo: RTL and testbench
===================================

Name: adc_capture_fifo

Overview:
Parametrised multi-channel ADC sampling front end for the RISC-V CPU. It replaces the single free-running adcdata word with round-robin capture of NCHAN channels. Captures are paced by an internal sample timer. Each sample is stored with its channel tag in a FIFO that the CPU drains through a registered read handshake.

Parameters:
DWIDTH, 32, bits per ADC channel sample and width of rd_data
NCHAN, 4, number of ADC channels (>=1); channel tag width CW = max(1, $clog2(NCHAN))
DEPTH, 8, FIFO entries (power of two, >=2)
SAMPLE_DIV, 16, clock cycles between sample captures (>=2)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active-low (reset==0 resets on the clock edge)
en  input  1  capture enable
adcdata  input  NCHAN*DWIDTH  packed channel samples; channel k = adcdata[k*DWIDTH +: DWIDTH]
rd_en  input  1  CPU read request, one entry per cycle
clr_ovf  input  1  clears overflow flag
rd_data  output  DWIDTH  popped sample
rd_chan  output  CW  channel tag of popped sample
rd_valid  output  1  rd_data/rd_chan valid this cycle
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky: at least one sample lost

Behaviour:
- Reset values (reset==0 at edge):
  - rd_data=0, rd_chan=0, rd_valid=0.
  - empty=1, full=0, count=0, overflow=0.
  - Timer=0, channel pointer=0.
  - FIFO pointers=0.
- Reset mid-operation discards all FIFO contents.
- Sample timer:
  - While en=1, the timer counts 0..SAMPLE_DIV-1 and wraps.
  - tick is asserted when timer==SAMPLE_DIV-1.
  - While en=0, the timer and channel pointer are forced to 0 and no captures occur.
  - The first capture after en rises occurs SAMPLE_DIV cycles later.
- Capture:
  - On tick, push {chan_ptr, adcdata slice chan_ptr}, sampled on that edge.
  - chan_ptr increments and wraps from NCHAN-1 to 0.
  - The pointer advances on every tick, even if the sample is dropped.
- Read:
  - rd_en=1 with count>0 pops the head entry.
  - rd_data/rd_chan are registered; rd_valid=1 on the following cycle only.
  - rd_en with empty=1 is ignored: rd_valid=0 next cycle, rd_data/rd_chan hold.
- Occupancy:
  - count, empty and full are registered and update the cycle after a push or pop.
  - empty = (count==0); full = (count==DEPTH).
- Simultaneous push and pop:
  - Both are performed and count is unchanged.
  - When full, the pop frees a slot for the push: no loss, no overflow.
  - When empty, only the push occurs; the pop is ignored and the new sample is not bypassed.
- Full with push and no pop: the new sample is dropped and overflow sets to 1.
- Overflow clearing:
  - clr_ovf=1 clears overflow next cycle.
  - If a drop occurs in the same cycle as clr_ovf, set wins.
- Pointers: read/write pointers wrap modulo DEPTH.
- FIFO storage is not reset; only pointers and count are.

Optional Feature:
Macro: ADC_DROP_OLDEST_EN.
- Defined:
  - A push when full with no pop overwrites the oldest entry: the read pointer advances along with the write pointer.
  - count stays DEPTH and overflow sets to 1.
  - The FIFO always holds the newest DEPTH samples.
- Undefined: the newest sample is dropped as described in Behaviour.

Test Plan:
1. Reset and enable:
   - Stimulus: NCHAN=4, SAMPLE_DIV=4, DEPTH=8; hold reset=0 for 2 cycles, then en=1.
   - Required: all outputs at reset values; first push exactly 4 cycles after en; count=1 one cycle later.
2. Round-robin capture:
   - Stimulus: adcdata channels 0..3 = 50, 200, 7, 0xFFFFFFFF; let 5 captures occur, then pop all.
   - Required: rd_chan sequence 0,1,2,3,0; rd_data sequence 50, 200, 7, 0xFFFFFFFF, 50; rd_valid one cycle after each rd_en.
3. Overflow (macro undefined):
   - Stimulus: DEPTH=8, no reads for 10 captures.
   - Required: full=1 after 8 captures; overflow=1 after the 9th; reading returns only the first 8 samples (chans 0..3,0..3).
   - Then clr_ovf=1 -> overflow=0.
4. Overflow (ADC_DROP_OLDEST_EN defined):
   - Stimulus: same as scenario 3.
   - Required: overflow=1; count=8; popped chans 2,3,0,1,2,3,0,1.
5. Simultaneous events and empty read:
   - Full FIFO with rd_en coinciding with a tick: count stays 8, overflow stays 0.
   - rd_en on empty: rd_valid=0, rd_data unchanged.
   - Drop and clr_ovf in the same cycle: overflow=1.
6. Mid-operation reset and disable:
   - Stimulus: reset=0 asserted with count=5.
   - Required next cycle: count=0, empty=1, overflow=0.
   - Stimulus: en=0 mid-count.
   - Required: no captures; chan_ptr restarts at 0 when en returns to 1.

Source files
------------

// File: rtl/adc_capture_fifo.sv
// Round-robin multi-channel ADC capture into a tagged FIFO with a registered read port.
// Optional build macro ADC_DROP_OLDEST_EN: when full, a new sample overwrites the oldest entry.
module adc_capture_fifo #(
  parameter int DWIDTH     = 32,
  parameter int NCHAN      = 4,
  parameter int DEPTH      = 8,
  parameter int SAMPLE_DIV = 16,
  localparam int CW        = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int AW        = $clog2(DEPTH),
  localparam int CNTW      = AW + 1,
  localparam int TW        = $clog2(SAMPLE_DIV)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NCHAN*DWIDTH-1:0] adcdata,
  input  logic                    rd_en,
  input  logic                    clr_ovf,
  output logic [DWIDTH-1:0]       rd_data,
  output logic [CW-1:0]           rd_chan,
  output logic                    rd_valid,
  output logic                    empty,
  output logic                    full,
  output logic [CNTW-1:0]         count,
  output logic                    overflow
);

  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        chan_q, chan_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]      count_q, count_d;
  logic                 empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
  logic [DWIDTH-1:0]    rd_data_q, rd_data_d;
  logic [CW-1:0]        rd_chan_q, rd_chan_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DWIDTH+CW-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0]    chan_data [NCHAN];

  logic tick, pop, at_full, drop, wr_en, rd_adv;

  for (genvar k = 0; k < NCHAN; k++) begin : g_slice
    assign chan_data[k] = adcdata[k*DWIDTH +: DWIDTH];
  end

  assign tick    = en && (timer_q == TW'(SAMPLE_DIV - 1));
  assign pop     = rd_en && (count_q != '0);
  assign at_full = (count_q == CNTW'(DEPTH));
  assign drop    = tick && at_full && !pop;

`ifdef ADC_DROP_OLDEST_EN
  // A drop overwrites the head slot, so the read side advances with the write side.
  assign wr_en  = tick;
  assign rd_adv = pop || drop;
`else
  assign wr_en  = tick && (!at_full || pop);
  assign rd_adv = pop;
`endif

  always_comb begin
    timer_d    = timer_q;
    chan_d     = chan_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNTW'(wr_en) - CNTW'(rd_adv);
    empty_d    = (count_d == '0);
    full_d     = (count_d == CNTW'(DEPTH));
    ovf_d      = clr_ovf ? 1'b0 : ovf_q;
    rd_data_d  = rd_data_q;
    rd_chan_d  = rd_chan_q;
    rd_valid_d = pop;

    if (!en) begin
      timer_d = '0;
      chan_d  = '0;
    end else if (tick) begin
      timer_d = '0;
      chan_d  = (chan_q == CW'(NCHAN - 1)) ? '0 : chan_q + CW'(1);
    end else begin
      timer_d = timer_q + TW'(1);
    end

    if (wr_en)  wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_adv) rd_ptr_d = rd_ptr_q + AW'(1);
    if (drop)   ovf_d    = 1'b1;

    if (pop) begin
      rd_data_d = mem_q[rd_ptr_q][DWIDTH-1:0];
      rd_chan_d = mem_q[rd_ptr_q][DWIDTH+CW-1:DWIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      timer_q    <= '0;
      chan_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_chan_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      chan_q     <= chan_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_chan_q  <= rd_chan_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers and count.
  always_ff @(posedge clock) begin
    if (reset && wr_en) mem_q[wr_ptr_q] <= {chan_q, chan_data[chan_q]};
  end

  assign rd_data  = rd_data_q;
  assign rd_chan  = rd_chan_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_adc_capture_fifo.sv
// Directed bench for adc_capture_fifo (NCHAN=4, DEPTH=8, SAMPLE_DIV=4), both overflow policies.
module tb_adc_capture_fifo;

  localparam int DWIDTH = 32;
  localparam int NCHAN  = 4;
  localparam int DEPTH  = 8;
  localparam int SDIV   = 4;

  logic                    clock = 1'b0;
  logic                    reset, en, rd_en, clr_ovf;
  logic [NCHAN*DWIDTH-1:0] adcdata;
  logic [DWIDTH-1:0]       rd_data;
  logic [1:0]              rd_chan;
  logic                    rd_valid, empty, full, overflow;
  logic [3:0]              count;

  int vectors = 0;
  int miscompares = 0;

  adc_capture_fifo #(
    .DWIDTH(DWIDTH), .NCHAN(NCHAN), .DEPTH(DEPTH), .SAMPLE_DIV(SDIV)
  ) dut (
    .clock(clock), .reset(reset), .en(en), .adcdata(adcdata),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(rd_data), .rd_chan(rd_chan),
    .rd_valid(rd_valid), .empty(empty), .full(full), .count(count),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] chan_val(input int ch);
    case (ch)
      0:       return 32'd50;
      1:       return 32'd200;
      2:       return 32'd7;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pop_chk(input string tag, input int ch);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk({tag, ".valid"}, 64'(rd_valid), 64'd1);
    chk({tag, ".chan"}, 64'(rd_chan), 64'(ch));
    chk({tag, ".data"}, 64'(rd_data), 64'(chan_val(ch)));
  endtask

  int exp3 [8];
  int exp5 [8];
  int last_ch;

  initial begin
`ifdef ADC_DROP_OLDEST_EN
    exp3 = '{2, 3, 0, 1, 2, 3, 0, 1};
    exp5 = '{2, 3, 0, 1, 2, 3, 0, 1};
`else
    exp3 = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp5 = '{1, 2, 3, 0, 1, 2, 3, 0};
`endif
    last_ch = exp5[7];
    reset   = 1'b0;
    en      = 1'b0;
    rd_en   = 1'b0;
    clr_ovf = 1'b0;
    adcdata = {32'hFFFF_FFFF, 32'd7, 32'd200, 32'd50};

    // Reset values and first capture latency
    step(2);
    chk("rst.rd_data", 64'(rd_data), 64'd0);
    chk("rst.rd_chan", 64'(rd_chan), 64'd0);
    chk("rst.rd_valid", 64'(rd_valid), 64'd0);
    chk("rst.empty", 64'(empty), 64'd1);
    chk("rst.full", 64'(full), 64'd0);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.overflow", 64'(overflow), 64'd0);
    reset = 1'b1;
    en    = 1'b1;
    step(3);
    chk("en.count_pre", 64'(count), 64'd0);
    step(1);
    chk("en.count_first", 64'(count), 64'd1);
    chk("en.empty_first", 64'(empty), 64'd0);

    // Round-robin capture of five samples, then drain
    step(16);
    chk("rr.count5", 64'(count), 64'd5);
    en = 1'b0;
    for (int i = 0; i < 5; i++) pop_chk($sformatf("rr.pop%0d", i), i % NCHAN);
    step(1);
    chk("rr.valid_drop", 64'(rd_valid), 64'd0);
    chk("rr.empty", 64'(empty), 64'd1);

    // Disable mid-count: no capture, channel pointer restarts
    en = 1'b1;
    step(2);
    en = 1'b0;
    step(3);
    chk("dis.count", 64'(count), 64'd0);

    // Overflow: ten captures without reads
    en = 1'b1;
    step(31);
    chk("ovf.count7", 64'(count), 64'd7);
    chk("ovf.full7", 64'(full), 64'd0);
    step(1);
    chk("ovf.full8", 64'(full), 64'd1);
    chk("ovf.ovf8", 64'(overflow), 64'd0);
    step(4);
    chk("ovf.ovf9", 64'(overflow), 64'd1);
    chk("ovf.count9", 64'(count), 64'd8);
    step(4);
    en = 1'b0;
    chk("ovf.count10", 64'(count), 64'd8);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("ovf.pop%0d", i), exp3[i]);
    step(1);
    chk("ovf.empty", 64'(empty), 64'd1);
    chk("ovf.sticky", 64'(overflow), 64'd1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("ovf.clr", 64'(overflow), 64'd0);

    // Full FIFO with pop on a tick, then drop coinciding with clr_ovf
    en = 1'b1;
    step(32);
    chk("sim.full", 64'(full), 64'd1);
    step(3);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk("sim.count", 64'(count), 64'd8);
    chk("sim.ovf", 64'(overflow), 64'd0);
    chk("sim.valid", 64'(rd_valid), 64'd1);
    chk("sim.chan", 64'(rd_chan), 64'd0);
    step(3);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    en      = 1'b0;
    chk("sim.set_wins", 64'(overflow), 64'd1);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("sim.pop%0d", i), exp5[i]);
    step(1);
    chk("sim.empty", 64'(empty), 64'd1);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk("emp.valid", 64'(rd_valid), 64'd0);
    chk("emp.chan_hold", 64'(rd_chan), 64'(last_ch));
    chk("emp.data_hold", 64'(rd_data), 64'(chan_val(last_ch)));
    chk("emp.count", 64'(count), 64'd0);

    // Mid-operation reset with five entries queued
    en = 1'b1;
    step(20);
    chk("mrst.count5", 64'(count), 64'd5);
    reset = 1'b0;
    en    = 1'b0;
    step(1);
    reset = 1'b1;
    chk("mrst.count", 64'(count), 64'd0);
    chk("mrst.empty", 64'(empty), 64'd1);
    chk("mrst.ovf", 64'(overflow), 64'd0);
    chk("mrst.data", 64'(rd_data), 64'd0);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk("mrst.no_pop", 64'(rd_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
